// File: rtl/error_sweep_reporter_pkg.sv
// Shared types and framing constants for the sweep error reporter.
// The frame is a marker byte, a tagged frequency byte and tagged 6-bit total chunks.
package err_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0] MARKER_BYTE = 8'h00;
  localparam logic       FREQ_TAG    = 1'b1;
  localparam logic [1:0] CHUNK_TAG   = 2'b01;
  localparam int         CHUNK_W     = 6;

  function automatic int num_chunks(input int cnt_w);
    return (cnt_w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/error_sweep_reporter_sat_counter.sv
// Per-channel saturating event counter with synchronous clear.
// Once it reaches all-ones it holds there until cleared.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset_counter,
  input  logic             clear,
  input  logic             enable,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLOCK_50 or posedge reset_counter) begin
    if (reset_counter) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign saturated = (count == CNT_MAX);

endmodule

// File: rtl/error_sweep_reporter.sv
// Settle / count / report engine for one step of the RAM frequency sweep.
// Counts per-channel error pulses over a window and streams a framed result to the UART.
module error_sweep_reporter
  import err_report_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 16384,
  parameter int SETTLE = 2048
) (
  input  logic              CLOCK_50,
  input  logic              reset_counter,
  input  logic              start,
  input  logic [8:0]        freq,
  input  logic [NUM_CH-1:0] error,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total,
  output logic              sat
);

  localparam int NC     = num_chunks(CNT_W);
  localparam int NB     = 2 + NC;
  localparam int PAD_W  = NC * CHUNK_W;
  localparam int SUM_W  = CNT_W + $clog2(NUM_CH);
  localparam int MAXC   = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CYC_W  = $clog2(MAXC + 1);
  localparam int IDX_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [CYC_W-1:0] cyc_reg;
  logic [8:0]       freq_q;
  logic [IDX_W-1:0] byte_idx_reg;
  logic             sum_pend_reg;

  logic             start_acc;
  logic             count_en;
  logic [CNT_W-1:0] ch_count [NUM_CH];
  logic [NUM_CH-1:0] ch_sat;
  logic [SUM_W-1:0] sum_all;
  logic [CNT_W-1:0] total_next;
  logic             total_ovf;
  logic [PAD_W-1:0] total_pad;
  logic [CHUNK_W-1:0] chunk;
  logic [7:0]       next_byte;
  logic             unused_freq_bits;

  assign start_acc = (state_reg == ST_IDLE) && start;
  assign count_en  = (state_reg == ST_COUNT);
  // Only the low seven frequency bits fit in the tagged frequency byte.
  assign unused_freq_bits = ^freq_q[8:7];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLOCK_50      (CLOCK_50),
      .reset_counter (reset_counter),
      .clear         (start_acc),
      .enable        (count_en),
      .inc           (error[gi]),
      .count         (ch_count[gi]),
      .saturated     (ch_sat[gi])
    );
  end

  // Sum is wide enough for NUM_CH full counters; clamp back to CNT_W.
  always_comb begin
    sum_all = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_all = sum_all + SUM_W'(ch_count[i]);
    end
    total_ovf  = (sum_all > SUM_W'(CNT_MAX));
    total_next = total_ovf ? CNT_MAX : sum_all[CNT_W-1:0];
  end

  assign total_pad = PAD_W'(total);

  always_comb begin
    chunk = '0;
    for (int k = 0; k < NC; k++) begin
      if (byte_idx_reg == IDX_W'(k + 2)) chunk = total_pad[k*CHUNK_W +: CHUNK_W];
    end
    case (byte_idx_reg)
      IDX_W'(0): next_byte = MARKER_BYTE;
      IDX_W'(1): next_byte = {FREQ_TAG, freq_q[6:0]};
      default:   next_byte = {CHUNK_TAG, chunk};
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset_counter) begin
    if (reset_counter) begin
      state_reg    <= ST_IDLE;
      cyc_reg      <= '0;
      freq_q       <= '0;
      byte_idx_reg <= '0;
      sum_pend_reg <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      total        <= '0;
      sat          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (|ch_sat) sat <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            freq_q    <= freq;
            total     <= '0;
            sat       <= 1'b0;
            cyc_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= (SETTLE == 0) ? ST_COUNT : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cyc_reg == CYC_W'(SETTLE - 1)) begin
            cyc_reg   <= '0;
            state_reg <= ST_COUNT;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        ST_COUNT: begin
          if (cyc_reg == CYC_W'(WINDOW - 1)) begin
            cyc_reg      <= '0;
            byte_idx_reg <= '0;
            sum_pend_reg <= 1'b1;
            state_reg    <= ST_SEND;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        ST_SEND: begin
          // First SEND cycle lets the last window cycle land in the counters before summing.
          if (sum_pend_reg) begin
            total        <= total_next;
            if (total_ovf) sat <= 1'b1;
            sum_pend_reg <= 1'b0;
          end else if (tx_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              if (byte_idx_reg == IDX_W'(NB - 1)) begin
                done      <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                byte_idx_reg <= byte_idx_reg + 1'b1;
              end
            end
          end else begin
            tx_data  <= next_byte;
            tx_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_error_sweep_reporter.sv
// Directed bench: two reporter instances (16-bit counts with settle, 6-bit counts without).
// Frames are captured by a handshake monitor stepped once per clock.
module tb_error_sweep_reporter;

  logic       clk;
  logic       rst;
  logic       start_a;
  logic       start_b;
  logic [8:0] freq;
  logic [1:0] err_in;
  logic       tx_ready;

  logic [7:0]  a_tx_data,  b_tx_data;
  logic        a_tx_valid, b_tx_valid;
  logic        a_busy,     b_busy;
  logic        a_done,     b_done;
  logic [15:0] a_total;
  logic [5:0]  b_total;
  logic        a_sat,      b_sat;

  error_sweep_reporter #(.NUM_CH(2), .CNT_W(16), .WINDOW(16), .SETTLE(4)) dut_a (
    .CLOCK_50(clk), .reset_counter(rst), .start(start_a), .freq(freq), .error(err_in),
    .tx_ready(tx_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .busy(a_busy),
    .done(a_done), .total(a_total), .sat(a_sat)
  );

  error_sweep_reporter #(.NUM_CH(2), .CNT_W(6), .WINDOW(100), .SETTLE(0)) dut_b (
    .CLOCK_50(clk), .reset_counter(rst), .start(start_b), .freq(freq), .error(err_in),
    .tx_ready(tx_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .busy(b_busy),
    .done(b_done), .total(b_total), .sat(b_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            sel;
    logic [8:0]      freq;
    logic [1:0]      err;
    logic [15:0]     exp_total;
    logic            exp_sat;
    int              nb;
    logic [4:0][7:0] exp_bytes;
  } vec_t;

  vec_t vecs [6];

  logic        sel;
  logic [7:0]  mon_data;
  logic        mon_valid, mon_busy, mon_done, mon_sat;
  logic [15:0] mon_total;

  always_comb begin
    mon_data  = a_tx_data;
    mon_valid = a_tx_valid;
    mon_busy  = a_busy;
    mon_done  = a_done;
    mon_sat   = a_sat;
    mon_total = a_total;
    if (sel) begin
      mon_data  = b_tx_data;
      mon_valid = b_tx_valid;
      mon_busy  = b_busy;
      mon_done  = b_done;
      mon_sat   = b_sat;
      mon_total = {10'd0, b_total};
    end
  end

  int n_cmp;
  int n_bad;
  int rx_n;
  int done_cnt;
  int mon_nb;
  logic [7:0] rx_bytes [8];
  logic       prev_valid, prev_xfer, gap_pending;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_clear();
    rx_n = 0; done_cnt = 0;
    prev_valid = 1'b0; prev_xfer = 1'b0; gap_pending = 1'b0; prev_data = 8'h00;
  endtask

  task automatic mon_step();
    logic xfer;
    if (prev_valid && !prev_xfer) begin
      chk("hold_valid", 32'(mon_valid), 32'd1);
      chk("hold_data", 32'(mon_data), 32'(prev_data));
    end
    if (gap_pending) begin
      if (rx_n < mon_nb) chk("present_after_gap", 32'(mon_valid), 32'd1);
      gap_pending = 1'b0;
    end
    if (prev_xfer) begin
      chk("gap", 32'(mon_valid), 32'd0);
      gap_pending = 1'b1;
    end
    if (mon_done) done_cnt++;
    xfer = mon_valid && tx_ready;
    if (xfer) begin
      if (rx_n < 8) rx_bytes[rx_n] = mon_data;
      rx_n++;
    end
    prev_valid = mon_valid;
    prev_data  = mon_data;
    prev_xfer  = xfer;
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic s, input logic [8:0] f);
    freq = f;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    freq = 9'h155;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
    tick();
    tick();
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 500 && !mon_valid; c++) tick();
    chk("valid_seen", 32'(mon_valid), 32'd1);
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    chk({tag, "_len"}, 32'(rx_n), 32'(v.nb));
    for (int b = 0; b < v.nb; b++) chk($sformatf("%s_byte%0d", tag, b), 32'(rx_bytes[b]), 32'(v.exp_bytes[b]));
    chk({tag, "_total"}, 32'(mon_total), 32'(v.exp_total));
    chk({tag, "_sat"}, 32'(mon_sat), 32'(v.exp_sat));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_end"}, 32'(mon_busy), 32'd0);
    $display("%s: sel=%0d total=%0d sat=%0b bytes=%0d done=%0d", tag, sel, mon_total, mon_sat, rx_n, done_cnt);
  endtask

  task automatic run_vec(input int i);
    sel = vecs[i].sel;
    mon_nb = vecs[i].nb;
    mon_clear();
    err_in = vecs[i].err;
    tx_ready = 1'b1;
    pulse_start(vecs[i].sel, vecs[i].freq);
    chk("busy_after_start", 32'(mon_busy), 32'd1);
    wait_done();
    err_in = 2'b00;
    check_frame(vecs[i], $sformatf("vec%0d", i));
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_tx_valid"}, 32'(mon_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(mon_data), 32'd0);
    chk({tag, "_busy"}, 32'(mon_busy), 32'd0);
    chk({tag, "_done"}, 32'(mon_done), 32'd0);
    chk({tag, "_total"}, 32'(mon_total), 32'd0);
    chk({tag, "_sat"}, 32'(mon_sat), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    err_in = 2'b00;
    mon_clear();
    $display("%s: reset applied", tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    vecs[0] = '{sel: 1'b0, freq: 9'h05A, err: 2'b01, exp_total: 16'd16, exp_sat: 1'b0, nb: 5,
                exp_bytes: {8'h40, 8'h40, 8'h50, 8'hDA, 8'h00}};
    vecs[1] = '{sel: 1'b0, freq: 9'h1FF, err: 2'b11, exp_total: 16'd32, exp_sat: 1'b0, nb: 5,
                exp_bytes: {8'h40, 8'h40, 8'h60, 8'hFF, 8'h00}};
    vecs[2] = '{sel: 1'b0, freq: 9'h100, err: 2'b10, exp_total: 16'd16, exp_sat: 1'b0, nb: 5,
                exp_bytes: {8'h40, 8'h40, 8'h50, 8'h80, 8'h00}};
    vecs[3] = '{sel: 1'b1, freq: 9'h0A3, err: 2'b11, exp_total: 16'd63, exp_sat: 1'b1, nb: 3,
                exp_bytes: {8'h00, 8'h00, 8'h7F, 8'hA3, 8'h00}};
    vecs[4] = '{sel: 1'b1, freq: 9'h012, err: 2'b01, exp_total: 16'd63, exp_sat: 1'b1, nb: 3,
                exp_bytes: {8'h00, 8'h00, 8'h7F, 8'h92, 8'h00}};
    vecs[5] = '{sel: 1'b1, freq: 9'h07F, err: 2'b00, exp_total: 16'd0, exp_sat: 1'b0, nb: 3,
                exp_bytes: {8'h00, 8'h00, 8'h40, 8'hFF, 8'h00}};

    sel = 1'b0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    freq = 9'h000; err_in = 2'b00; tx_ready = 1'b1; mon_nb = 5;
    mon_clear();
    @(posedge clk); @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_tx_valid", 32'(mon_valid), 32'd0);
      chk("rst_tx_data", 32'(mon_data), 32'd0);
      chk("rst_busy", 32'(mon_busy), 32'd0);
      chk("rst_total", 32'(mon_total), 32'd0);
      chk("rst_sat", 32'(mon_sat), 32'd0);
    end
    rst = 1'b0;
    sel = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Back-pressure: byte0 must be held for 200 cycles, then the frame arrives once.
    sel = 1'b0; mon_nb = 5; mon_clear();
    err_in = 2'b01; tx_ready = 1'b0;
    pulse_start(1'b0, 9'h05A);
    wait_valid();
    for (int c = 0; c < 200; c++) tick();
    chk("stall_valid", 32'(mon_valid), 32'd1);
    chk("stall_data", 32'(mon_data), 32'h00);
    chk("stall_nothing_rx", 32'(rx_n), 32'd0);
    tx_ready = 1'b1;
    wait_done();
    err_in = 2'b00;
    check_frame(vecs[0], "stall");

    // Errors in SETTLE ignored; last COUNT cycle counted; first cycle after window ignored.
    begin
      vec_t v;
      v = '{sel: 1'b0, freq: 9'h033, err: 2'b00, exp_total: 16'd1, exp_sat: 1'b0, nb: 5,
            exp_bytes: {8'h40, 8'h40, 8'h41, 8'hB3, 8'h00}};
      sel = 1'b0; mon_nb = 5; mon_clear(); tx_ready = 1'b1; err_in = 2'b00;
      pulse_start(1'b0, 9'h033);
      for (int k = 2; k <= 22; k++) begin
        if (k >= 2 && k <= 5) err_in = 2'b11;
        else if (k == 21) err_in = 2'b01;
        else if (k == 22) err_in = 2'b10;
        else err_in = 2'b00;
        tick();
      end
      err_in = 2'b00;
      wait_done();
      check_frame(v, "window_edges");
    end

    // Start while busy (during SETTLE and during COUNT) is ignored.
    sel = 1'b0; mon_nb = 5; mon_clear(); tx_ready = 1'b1; err_in = 2'b01;
    pulse_start(1'b0, 9'h05A);
    tick(); tick();
    pulse_start(1'b0, 9'h1FF);
    for (int c = 0; c < 6; c++) tick();
    pulse_start(1'b0, 9'h1FF);
    wait_done();
    err_in = 2'b00;
    check_frame(vecs[0], "restart_ignored");

    // Reset mid-COUNT on instance A.
    sel = 1'b0; mon_clear(); err_in = 2'b11;
    pulse_start(1'b0, 9'h0F0);
    for (int c = 0; c < 8; c++) tick();
    async_reset_check("rst_count");
    run_vec(0);

    // Reset mid-SEND on instance B, with a saturated result already registered.
    sel = 1'b1; mon_nb = 3; mon_clear(); err_in = 2'b11; tx_ready = 1'b0;
    pulse_start(1'b1, 9'h0A3);
    wait_valid();
    tick();
    chk("pre_rst_sat", 32'(mon_sat), 32'd1);
    async_reset_check("rst_send");
    tx_ready = 1'b1;
    run_vec(3);
    run_vec(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/error_sweep_reporter.md
Name: error_sweep_reporter

Overview:
Parametrised measurement-and-report engine for the RAM frequency sweep. After each frequency step it runs a settle period, then counts per-channel error pulses over a fixed window. It then streams a framed result record (marker, frequency, total error count split into 6-bit chunks) to the UART transmitter using a valid/ready handshake instead of fixed wait delays. It replaces the hard-wired two-channel, 16-bit counting and reporting path in the sweep controller.

Parameters:
NUM_CH, 2, number of independent error inputs (1..8)
CNT_W, 16, width of each per-channel counter and of the total (6..30)
WINDOW, 16384, count-window length in CLOCK_50 cycles (>=1)
SETTLE, 2048, settle length in CLOCK_50 cycles before counting (>=0)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset_counter  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins one measurement at the current frequency
freq  in  9  current PLL frequency code; sampled on accepted start
error  in  NUM_CH  per-channel error flags, synchronous to CLOCK_50
tx_ready  in  1  UART idle and able to accept a byte
tx_data  out  8  byte presented to the UART
tx_valid  out  1  tx_data valid; held until accepted
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last byte is accepted
total  out  CNT_W  saturating sum of the channel counts; stable after COUNT ends
sat  out  1  high if any channel count or the total saturated in this measurement

Behaviour:
- Clock CLOCK_50; reset reset_counter, asynchronous, active-high. On reset: state IDLE, all counters 0, tx_data=0, tx_valid=0, busy=0, done=0, total=0, sat=0.
- States: IDLE, SETTLE, COUNT, SEND, DONE.
- IDLE: start=1 latches freq into freq_q, clears the channel counters, total, sat and the cycle counter, and sets busy. The next state is SETTLE, or COUNT if SETTLE=0.
- start while busy=1 is ignored. It does not restart the measurement and does not relatch freq.
- SETTLE: cycle counter runs. Exactly SETTLE cycles are spent in SETTLE, then COUNT; cycle counter cleared on the transition. error inputs are ignored.
- COUNT: exactly WINDOW cycles. In each cycle, every channel i with error[i]=1 increments counter i by 1.
- Channel counters saturate at 2^CNT_W-1. Saturation sets sat and it stays set until the next accepted start.
- Last COUNT cycle: that cycle's errors are included. The next cycle, total is registered as the sum of all channels, saturated to 2^CNT_W-1 (sum computed at CNT_W+clog2(NUM_CH) bits; overflow sets sat). Then SEND.
- SEND: byte sequence NB = 2 + ceil(CNT_W/6):
  - byte0 = 0x00 (frame marker)
  - byte1 = {1'b1, freq_q[6:0]}
  - byte2.. = {2'b01, total[6k+5:6k]} for k=0 upward, LSB chunk first; bits above CNT_W-1 are zero-padded
- Handshake: a byte transfers on a cycle with tx_valid=1 and tx_ready=1.
  - Once tx_valid is high, tx_data must not change until the transfer.
  - On the cycle after a transfer, tx_valid is 0 for exactly one cycle (gap for the UART to drop tx_ready), then the next byte is presented.
  - tx_ready low for any duration only stalls; no byte is lost or duplicated.
- After the last byte transfers: DONE for one cycle with done=1, then IDLE with busy=0. total and sat hold until the next accepted start.
- Reset in any state aborts immediately: tx_valid drops, no partial frame is resumed.
- The cycle counter width is clog2(max(WINDOW,SETTLE)+1); no wrap is possible within a state.

Decomposition:
- Package err_report_pkg:
  - state enum
  - MARKER_BYTE=8'h00, FREQ_TAG=1'b1, CHUNK_TAG=2'b01, CHUNK_W=6
  - function num_chunks(CNT_W)
- Sub-module sat_counter (CNT_W): clear, enable and increment inputs; count and saturated outputs. Instantiated NUM_CH times in a generate loop.

Test Plan:
- NUM_CH=2, CNT_W=16, WINDOW=16, SETTLE=4, freq=9'h05A, error[0] held 1, error[1] 0, tx_ready=1 -> total=16, sat=0, bytes 00, DA, 50, 40, 40, then one done pulse.
- CNT_W=6, WINDOW=100, both errors held 1 -> each channel=63, total=63, sat=1, chunk byte 0x7F.
- Hold tx_ready=0 for 200 cycles after byte0 is presented -> tx_valid stays 1 and tx_data stays 0x00. After release, the full frame arrives exactly once.
- error pulses only during SETTLE, plus one pulse on the last COUNT cycle -> total=1.
- Assert reset_counter mid-COUNT and mid-SEND -> all outputs 0 in the same cycle. A fresh start then produces a correct, complete frame.
- Second start pulse while busy -> ignored; exactly one frame emitted, with the freq value from the first start.
